// File: rtl/simple_tx_mcdma_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// simple_tx_mcdma_pkg : FSM state type, default sizes, round-robin pick
// Rev 1.0
//------------------------------------------------------------------
package simple_tx_mcdma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int C_NUM_CH      = 4;
  localparam int C_CH_W        = 2;
  localparam int C_ADDR_W      = 32;
  localparam int C_LEN_W       = 16;
  localparam int C_DATA_W      = 32;
  localparam int C_FIFO_DEPTH  = 8;
  localparam int C_STALL_LIMIT = 1024;
  localparam int C_MAX_CH      = 32;

  // First pending channel strictly after 'last' in circular order, -1 if none.
  function automatic int rr_next(input logic [C_MAX_CH-1:0] pending,
                                 input int last, input int num_ch);
    logic [4:0] idx;
    rr_next = -1;
    for (int k = C_MAX_CH; k >= 1; k--) begin
      idx = 5'((last + k) & (num_ch - 1));
      if (k <= num_ch && pending[idx]) rr_next = int'({27'd0, idx});
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/simple_tx_mcdma_fifo.sv
`default_nettype none
//------------------------------------------------------------------
// simple_tx_mcdma_fifo : synchronous FIFO, show-ahead read port
// Rev 1.0
//------------------------------------------------------------------
module simple_tx_mcdma_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/simple_tx_mcdma_core.sv
`default_nettype none
//------------------------------------------------------------------
// simple_tx_mcdma_core : round-robin Tx multichannel DMA to AXI4-Stream
// Rev 1.0
//------------------------------------------------------------------
module simple_tx_mcdma_core
  import simple_tx_mcdma_pkg::*;
#(
  parameter int NUM_CH      = C_NUM_CH,
  parameter int CH_W        = C_CH_W,
  parameter int ADDR_W      = C_ADDR_W,
  parameter int LEN_W       = C_LEN_W,
  parameter int DATA_W      = C_DATA_W,
  parameter int FIFO_DEPTH  = C_FIFO_DEPTH,
  parameter int STALL_LIMIT = C_STALL_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_chan,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic [DATA_W-1:0] rd_rsp_data,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [CH_W-1:0]   m_axis_tdest,
  output logic              done_valid,
  output logic [CH_W-1:0]   done_chan,
  output logic              busy,
  output logic              stall_block
);
  localparam int C_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int C_WD_W  = $clog2(STALL_LIMIT + 1);
  localparam logic [C_CNT_W:0]  C_DEPTH_V = (C_CNT_W+1)'(FIFO_DEPTH);
  localparam logic [C_WD_W-1:0] C_WD_MAX  = C_WD_W'(STALL_LIMIT);

  state_t             r_state, w_state_next;
  logic [NUM_CH-1:0]  r_pending;
  logic [ADDR_W-1:0]  r_slot_addr [NUM_CH];
  logic [LEN_W-1:0]   r_slot_len  [NUM_CH];
  logic [CH_W-1:0]    r_chan, r_last_ptr;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len, r_issued, r_sent;
  logic [C_CNT_W-1:0] r_outstanding;
  logic [C_WD_W-1:0]  r_wd_cnt, w_wd_next;
  logic               r_stall;

  int                 w_grant_idx;
  logic               w_grant, w_cmd_fire, w_req_fire, w_rsp_take;
  logic               w_beat_fire, w_last_beat, w_credit, w_stalled;
  logic [CH_W-1:0]    w_grant_ch;
  logic [C_CNT_W-1:0] w_fifo_count;
  logic               w_fifo_full, w_fifo_empty;
  logic [DATA_W-1:0]  w_fifo_head;

  assign cmd_ready   = ~reset & ~r_pending[cmd_chan];
  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_grant_idx = rr_next(C_MAX_CH'(r_pending), int'(r_last_ptr), NUM_CH);
  assign w_grant     = (r_state == ST_IDLE) && (w_grant_idx >= 0);
  assign w_grant_ch  = w_grant_idx[CH_W-1:0];

  // Buffered plus in-flight words never exceed the FIFO, so responses always fit.
  assign w_credit     = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < C_DEPTH_V;
  assign rd_req_valid = (r_state == ST_XFER) && (r_issued != r_len) && w_credit;
  assign rd_req_addr  = r_addr + ADDR_W'(r_issued);
  assign w_req_fire   = rd_req_valid & rd_req_ready;
  assign w_rsp_take   = rd_rsp_valid && (r_state == ST_XFER) && (r_outstanding != '0) && !w_fifo_full;

  assign m_axis_tvalid = (r_state == ST_XFER) && !w_fifo_empty;
  assign m_axis_tdata  = w_fifo_head;
  assign m_axis_tdest  = r_chan;
  assign w_last_beat   = (r_sent == r_len - 1'b1);
  assign m_axis_tlast  = m_axis_tvalid & w_last_beat;
  assign w_beat_fire   = m_axis_tvalid & m_axis_tready;

  simple_tx_mcdma_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (w_rsp_take),
    .push_data (rd_rsp_data),
    .pop       (w_beat_fire),
    .pop_data  (w_fifo_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = (r_len == '0) ? ST_DONE : ST_XFER;
      ST_XFER: if (w_beat_fire && w_last_beat) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done_valid = 1'b0;
    done_chan  = '0;
    busy       = (|r_pending) || (r_state != ST_IDLE);
    if (r_state == ST_DONE) begin
      done_valid = 1'b1;
      done_chan  = r_chan;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cmd_fire && cmd_chan == CH_W'(i))     r_pending[i] <= 1'b1;
        else if (w_grant && w_grant_ch == CH_W'(i)) r_pending[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_cmd_fire) begin
      r_slot_addr[cmd_chan] <= cmd_addr;
      r_slot_len[cmd_chan]  <= cmd_len;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_chan        <= '0;
      r_last_ptr    <= CH_W'(NUM_CH - 1);
      r_addr        <= '0;
      r_len         <= '0;
      r_issued      <= '0;
      r_sent        <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_grant) begin
        r_chan     <= w_grant_ch;
        r_last_ptr <= w_grant_ch;
        r_addr     <= r_slot_addr[w_grant_ch];
        r_len      <= r_slot_len[w_grant_ch];
        r_issued   <= '0;
        r_sent     <= '0;
      end else begin
        if (w_req_fire)  r_issued <= r_issued + 1'b1;
        if (w_beat_fire) r_sent   <= r_sent + 1'b1;
      end
      case ({w_req_fire, w_rsp_take})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: ;
      endcase
    end
  end

  // Watchdog: counts consecutive back-pressured cycles, saturating at the limit.
  assign w_stalled = m_axis_tvalid & ~m_axis_tready;
  always_comb begin
    w_wd_next = '0;
    if (w_stalled) w_wd_next = (r_wd_cnt == C_WD_MAX) ? r_wd_cnt : r_wd_cnt + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_next;
      r_stall  <= (w_wd_next >= C_WD_MAX);
    end
  end
  assign stall_block = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_simple_tx_mcdma_core.sv
`default_nettype none
//------------------------------------------------------------------
// tb_simple_tx_mcdma_core : scoreboard bench with 1-cycle memory model
// Rev 1.0
//------------------------------------------------------------------
module tb_simple_tx_mcdma_core;
  localparam int CH_W = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_chan = '0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic        rd_req_valid;
  logic        rd_req_ready = 1'b1;
  logic [31:0] rd_req_addr;
  logic        rd_rsp_valid = 1'b0;
  logic [31:0] rd_rsp_data = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tdest;
  logic        done_valid;
  logic [1:0]  done_chan;
  logic        busy;
  logic        stall_block;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  dest;
    logic        last;
  } beat_t;

  beat_t       exp_beats[$];
  logic [1:0]  exp_done[$];
  beat_t       b;
  logic [1:0]  dch;
  int n_checks = 0, n_fail = 0;
  int n_beats = 0, n_req = 0, n_tlast = 0;
  int inflight = 0, max_inflight = 0;

  always #5 clock = ~clock;

  simple_tx_mcdma_core #(
    .NUM_CH(4), .CH_W(CH_W), .ADDR_W(32), .LEN_W(16), .DATA_W(32),
    .FIFO_DEPTH(8), .STALL_LIMIT(16)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chan(cmd_chan),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .done_valid(done_valid), .done_chan(done_chan), .busy(busy), .stall_block(stall_block)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle latency memory, responses in request order.
  always @(posedge clock) begin
    rd_rsp_valid <= rd_req_valid & rd_req_ready;
    rd_rsp_data  <= mem_word(rd_req_addr);
  end

  always @(negedge clock) begin
    if (reset) begin
      inflight = 0;
    end else begin
      if (rd_req_valid && rd_req_ready) begin
        n_req++;
        inflight++;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_beats++;
        inflight--;
        if (m_axis_tlast) n_tlast++;
        check_eq("beat_expected", exp_beats.size() != 0, 1);
        if (exp_beats.size() != 0) begin
          b = exp_beats.pop_front();
          check_eq("tdata", m_axis_tdata, b.data);
          check_eq("tdest", m_axis_tdest, b.dest);
          check_eq("tlast", m_axis_tlast, b.last);
        end
      end
      if (inflight > max_inflight) max_inflight = inflight;
      if (done_valid) begin
        check_eq("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          dch = exp_done.pop_front();
          check_eq("done_chan", done_chan, dch);
        end
      end
    end
  end

  // Entered and left at posedge+#1.
  task automatic send_cmd(input logic [1:0] ch, input logic [31:0] addr, input logic [15:0] len);
    int t = 0;
    beat_t e;
    cmd_valid = 1'b1; cmd_chan = ch; cmd_addr = addr; cmd_len = len;
    @(negedge clock);
    while (!cmd_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    check_eq("cmd_accept", cmd_ready, 1);
    for (int i = 0; i < int'(len); i++) begin
      e.data = mem_word(addr + 32'(i));
      e.dest = ch;
      e.last = (i == int'(len) - 1);
      exp_beats.push_back(e);
    end
    exp_done.push_back(ch);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((exp_beats.size() != 0 || exp_done.size() != 0) && t < budget) begin
      @(posedge clock);
      t++;
    end
    #1;
    check_eq("drain", exp_beats.size() + exp_done.size(), 0);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int t = 0;
    while (n_beats < target && t < budget) begin
      @(posedge clock); #1;
      t++;
    end
    check_eq("wait_beats", n_beats >= target, 1);
  endtask

  task automatic check_quiet();
    check_eq("q_cmd_ready", cmd_ready, 0);
    check_eq("q_rd_req_valid", rd_req_valid, 0);
    check_eq("q_tvalid", m_axis_tvalid, 0);
    check_eq("q_tlast", m_axis_tlast, 0);
    check_eq("q_done_valid", done_valid, 0);
    check_eq("q_busy", busy, 0);
    check_eq("q_stall_block", stall_block, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base, req0, tl0;
    logic [31:0] hold;
    int t;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check_quiet();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_eq("ready_after_reset", cmd_ready, 1);
    @(posedge clock); #1;

    // Single transfer ch1
    send_cmd(2'd1, 32'h100, 16'd4);
    drain(100);
    @(negedge clock);
    check_eq("busy_after_t1", busy, 0);
    @(posedge clock); #1;

    // Three channels back to back; ch0 is alone when granted, then 2, 3 follow round-robin
    tl0 = n_tlast;
    send_cmd(2'd0, 32'h010, 16'd2);
    send_cmd(2'd2, 32'h020, 16'd3);
    send_cmd(2'd3, 32'h030, 16'd1);
    drain(200);
    @(negedge clock);
    check_eq("busy_after_t2", busy, 0);
    check_eq("tlast_count", n_tlast - tl0, 3);
    @(posedge clock); #1;

    // Back-pressure for 20 cycles mid-transfer
    max_inflight = 0;
    base = n_beats;
    send_cmd(2'd1, 32'h200, 16'd12);
    wait_beats(base + 2, 100);
    m_axis_tready = 1'b0;
    @(negedge clock);
    hold = m_axis_tdata;
    repeat (19) @(negedge clock);
    check_eq("hold_tvalid", m_axis_tvalid, 1);
    check_eq("hold_tdata", m_axis_tdata, hold);
    @(posedge clock); #1;
    m_axis_tready = 1'b1;
    drain(200);
    check_eq("max_inflight", max_inflight, 8);

    // Watchdog with limit 16
    m_axis_tready = 1'b0;
    send_cmd(2'd2, 32'h040, 16'd2);
    t = 0;
    @(negedge clock);
    while (!m_axis_tvalid && t < 50) begin
      @(negedge clock);
      t++;
    end
    check_eq("stall_tvalid", m_axis_tvalid, 1);
    repeat (15) @(negedge clock);
    check_eq("stall_after_15", stall_block, 0);
    @(negedge clock);
    check_eq("stall_after_16", stall_block, 1);
    @(posedge clock); #1;
    m_axis_tready = 1'b1;
    @(negedge clock);
    check_eq("stall_in_hs", stall_block, 1);
    @(posedge clock); #1;
    m_axis_tready = 1'b0;
    @(negedge clock);
    check_eq("stall_clr", stall_block, 0);
    @(posedge clock); #1;
    m_axis_tready = 1'b1;
    drain(50);

    // Zero-length transfer and a refused duplicate on a pending channel
    req0 = n_req;
    base = n_beats;
    send_cmd(2'd2, 32'h500, 16'd0);
    cmd_valid = 1'b1; cmd_chan = 2'd2; cmd_addr = 32'h600; cmd_len = 16'd7;
    @(negedge clock);
    check_eq("cmd_ready_pending", cmd_ready, 0);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    drain(20);
    check_eq("len0_no_req", n_req - req0, 0);
    check_eq("len0_no_beat", n_beats - base, 0);

    // Reset during beat 2 of 5, then a wrapping transfer
    base = n_beats;
    send_cmd(2'd0, 32'h300, 16'd5);
    wait_beats(base + 1, 100);
    reset = 1'b1;
    exp_beats.delete();
    exp_done.delete();
    @(posedge clock);
    @(negedge clock);
    check_quiet();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check_eq("busy_post_reset", busy, 0);
    @(posedge clock); #1;
    send_cmd(2'd3, 32'hFFFF_FFFE, 16'd4);
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
